// File: rtl/p2s_shift_ctrl.sv
// p2s_shift_ctrl: serialises a DATA_W-bit word MSB-first onto a 3-wire bus
// (s_dat / s_clk / s_latch) for cascaded shift-register peripherals.
// Each bit is presented with s_clk low for DIV cycles, then s_clk high for
// DIV cycles. After the last bit, s_latch is held high for DIV cycles, and a
// one-cycle done pulse follows.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   start, din          frame request + data (sampled only when not busy)
//   busy, done          handshake: frame in progress / completion pulse
//   s_clk, s_dat        serial shift clock and data to the peripheral
//   s_latch             storage-register latch strobe
// Every output is a flop. Its next value is decoded from the next state, so
// outputs line up with the state register and never depend on inputs
// combinationally.
module p2s_shift_ctrl #(
  parameter int DATA_W = 64,
  parameter int DIV    = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic              s_clk,
  output logic              s_dat,
  output logic              s_latch
);

  typedef enum logic [2:0] {IDLE, SH_LO, SH_HI, LATCH, DONE} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic               busy_q, done_q, sclk_q, sdat_q, slatch_q;
  logic               busy_d, done_d, sclk_d, sdat_d, slatch_d;
  logic               last_phase;

  assign last_phase = (phase_q == CNT_W'(DIV - 1));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    case (state_q)
      // DONE counts as idle, so a held start chains frames with a
      // single-cycle gap.
      IDLE, DONE: begin
        if (start) begin
          shreg_d = din;
          bit_d   = CNT_W'(DATA_W - 1);
          phase_d = '0;
          state_d = SH_LO;
        end else begin
          state_d = IDLE;
        end
      end
      SH_LO: begin
        if (last_phase) begin
          phase_d = '0;
          state_d = SH_HI;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SH_HI: begin
        if (last_phase) begin
          phase_d = '0;
          if (bit_q == '0) begin
            state_d = LATCH;
          end else begin
            // Shift only after the high phase, so s_dat is held across
            // the peripheral's sampling edge.
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            bit_d   = bit_q - 1'b1;
            state_d = SH_LO;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      LATCH: begin
        if (last_phase) begin
          phase_d = '0;
          state_d = DONE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        phase_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state.
  always_comb begin
    busy_d   = (state_d == SH_LO) || (state_d == SH_HI) || (state_d == LATCH);
    done_d   = (state_d == DONE);
    sclk_d   = (state_d == SH_HI);
    slatch_d = (state_d == LATCH);
    sdat_d   = ((state_d == SH_LO) || (state_d == SH_HI)) && shreg_d[DATA_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bit_q    <= '0;
      phase_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sdat_q   <= 1'b0;
      slatch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      sdat_q   <= sdat_d;
      slatch_q <= slatch_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign s_clk   = sclk_q;
  assign s_dat   = sdat_q;
  assign s_latch = slatch_q;

endmodule

// File: doc/p2s_shift_ctrl.md
Name: p2s_shift_ctrl

Overview:
- Sequencer that serialises a parallel word MSB-first onto a 3-wire serial bus (data, shift clock, latch) for cascaded shift-register peripherals such as LED/7-segment display chains.
- Owns an internal load/shift register and generates the slow shift clock from the system clock.
- Uses a start/busy/done handshake, so upstream logic (display refresh, top-level FSM) writes one frame at a time.

Parameters:
- DATA_W, 64, frame width in bits (>=2); one serial bit per register bit.
- DIV, 4, shift-clock half-period in clk cycles (>=1).
- CNT_W, 8, width of bit and phase counters; must hold max(DATA_W-1, DIV-1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  frame request, sampled only while busy=0.
- din  input  DATA_W  frame data, captured on the accepting edge.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame completion.
- s_clk  output  1  serial shift clock to peripheral.
- s_dat  output  1  serial data, MSB first.
- s_latch  output  1  storage-register latch strobe to peripheral.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE; busy=0, done=0, s_clk=0, s_dat=0, s_latch=0; internal shreg, bit_cnt and phase_cnt cleared.
- Reset mid-frame aborts immediately. No latch pulse is issued and done stays low. After release, the block waits in IDLE for a new start.
- All outputs are registered; none is combinational from any input.
- States: IDLE, SH_LO, SH_HI, LATCH, DONE.
- IDLE:
  - busy=0, s_clk=0, s_latch=0.
  - On start=1: shreg<=din, bit_cnt<=DATA_W-1, phase_cnt<=0, go to SH_LO.
- SH_LO:
  - busy=1, s_clk=0, s_dat=shreg[DATA_W-1].
  - Lasts exactly DIV cycles, then go to SH_HI.
- SH_HI:
  - s_clk=1; s_dat is held, so the peripheral samples on the s_clk rising edge.
  - Lasts DIV cycles.
  - At the end, if bit_cnt=0, go to LATCH.
  - Otherwise shreg<=shreg<<1 (zero fill), bit_cnt<=bit_cnt-1, return to SH_LO.
- LATCH: s_clk=0, s_dat=0, s_latch=1 for DIV cycles, then go to DONE.
- DONE: one cycle with busy=0, done=1, s_latch=0, then go to IDLE.
- Latency:
  - busy is high for exactly 2*DIV*DATA_W + DIV cycles, starting the cycle after the accepting edge.
  - done follows in the next cycle.
  - The next start can be accepted on the DONE cycle edge; DONE counts as not busy.
- Exactly DATA_W rising edges of s_clk and exactly one s_latch pulse per frame.
- start while busy=1 is ignored; it is not queued.
- din changes after the accepting edge have no effect on the current frame.
- start held high continuously produces back-to-back frames. The gap from DONE to SH_LO is one cycle.
- DIV=1: s_clk toggles every cycle and the latch pulse is one cycle wide. No phase is skipped.
- Counters never wrap: phase_cnt resets to 0 on every state change, and bit_cnt is only decremented while non-zero.

Test Plan:
- Reset values: assert rst_n=0 with random inputs -> all five outputs are 0; after release with start=0 for 20 cycles, outputs stay 0 and no s_clk edges occur.
- Single frame (DATA_W=8, DIV=2, din=8'hA5, start one cycle):
  - Sampling s_dat at each s_clk rising edge yields 1,0,1,0,0,1,0,1.
  - busy is high for 34 cycles; s_latch is high for 2 cycles, after the 8th s_clk rising edge; done pulses once, immediately after.
- Ignored start: issue start with din=8'hFF at cycle 10 of a frame carrying 8'h3C -> serial stream is still 0,0,1,1,1,1,0,0 and only one done pulse occurs.
- Back-to-back frames (DIV=1, start held high, din=8'h01 then 8'h80): two frames of 17 busy cycles each, separated by a single DONE cycle; streams are 00000001 and 10000000; two latch pulses.
- Mid-frame reset: drop rst_n during the 5th SH_HI phase -> outputs clear in the same cycle (asynchronously), with no s_latch and no done. A fresh start after release sends the full frame correctly.
- Default parameters (DATA_W=64, DIV=4), din=64'h0123_4567_89AB_CDEF -> 64 s_clk rising edges, captured word equals din, and busy lasts 516 cycles.
